// File: rtl/pe_pkg.sv
// pe_pkg: shared defaults, output-register states and counter sizing for the PE accumulator
package pe_pkg;
    localparam int P_W_DEF     = 12;
    localparam int ACC_W_DEF   = 20;
    localparam int N_TERMS_DEF = 4;
    localparam int unsigned ACC_MAX_DEF = (1 << ACC_W_DEF) - 1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_t;

    // Term counter width, never below one bit so N_TERMS=1 still has a (constant-zero) counter
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/pe_sat_add.sv
// pe_sat_add: unsigned saturating add of a zero-extended product onto the accumulator
module pe_sat_add
    import pe_pkg::*;
#(
    parameter int P_W   = P_W_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic [ACC_W-1:0] i_a,
    input  logic [P_W-1:0]   i_b,
    output logic [ACC_W-1:0] o_sum,
    output logic             o_ovf
);
    logic [ACC_W:0] w_full;

    assign w_full = {1'b0, i_a} + {{(ACC_W + 1 - P_W){1'b0}}, i_b};
    assign o_ovf  = w_full[ACC_W];
    assign o_sum  = o_ovf ? {ACC_W{1'b1}} : w_full[ACC_W-1:0];
endmodule

// File: rtl/pe_accum.sv
// pe_accum: sums N_TERMS products per group and presents each result on a ready/valid register
module pe_accum
    import pe_pkg::*;
#(
    parameter int P_W     = P_W_DEF,
    parameter int ACC_W   = ACC_W_DEF,
    parameter int N_TERMS = N_TERMS_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [P_W-1:0]   p_in,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_sat
);
    localparam int CNT_W = cnt_w(N_TERMS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TERMS - 1);

    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sat_acc;
    out_state_t       r_state;
    out_state_t       w_state_nxt;
    logic [ACC_W-1:0] w_sum;
    logic             w_ovf;
    logic             w_last;
    logic             w_accept;
    logic             w_final;
    logic             w_pop;

    pe_sat_add #(.P_W(P_W), .ACC_W(ACC_W)) u_add (
        .i_a   (r_acc),
        .i_b   (p_in),
        .o_sum (w_sum),
        .o_ovf (w_ovf)
    );

    // Only stall when the final term would overwrite a result the consumer has not taken
    assign w_last    = (r_cnt == LAST);
    assign out_valid = (r_state == FULL);
    assign in_ready  = en & ~(out_valid & ~out_ready & w_last);
    assign w_accept  = in_valid & in_ready;
    assign w_final   = w_accept & w_last;
    assign w_pop     = out_valid & out_ready;

    // Partial-group accumulation; restarts from zero after each final term
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            r_sat_acc <= 1'b0;
        end else if (clr || w_final) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            r_sat_acc <= 1'b0;
        end else if (w_accept) begin
            r_acc     <= w_sum;
            r_cnt     <= r_cnt + 1'b1;
            r_sat_acc <= r_sat_acc | w_ovf;
        end
    end

    // Output occupancy state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= EMPTY;
        else        r_state <= w_state_nxt;
    end

    // A final term refills the slot even when it is popped in the same cycle
    always_comb begin
        w_state_nxt = clr ? EMPTY : w_final ? FULL : w_pop ? EMPTY : r_state;
    end

    // Result data, loaded on the final term and otherwise held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_sum <= '0;
            out_sat <= 1'b0;
        end else if (clr) begin
            out_sum <= '0;
            out_sat <= 1'b0;
        end else if (w_final) begin
            out_sum <= w_sum;
            out_sat <= r_sat_acc | w_ovf;
        end
    end
endmodule

// File: tb/tb_pe_accum.sv
// tb_pe_accum: directed checks of pe_accum with a 20-bit and a 12-bit accumulator in parallel
module tb_pe_accum;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        clr;
    logic        in_valid;
    logic [11:0] p_in;
    logic        out_ready;
    logic        in_ready_a, out_valid_a, out_sat_a;
    logic [19:0] out_sum_a;
    logic        in_ready_b, out_valid_b, out_sat_b;
    logic [11:0] out_sum_b;
    int          n_chk = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    pe_accum #(.P_W(12), .ACC_W(20), .N_TERMS(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .in_valid(in_valid), .p_in(p_in),
        .in_ready(in_ready_a), .out_valid(out_valid_a), .out_ready(out_ready),
        .out_sum(out_sum_a), .out_sat(out_sat_a)
    );

    pe_accum #(.P_W(12), .ACC_W(12), .N_TERMS(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .in_valid(in_valid), .p_in(p_in),
        .in_ready(in_ready_b), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_sum(out_sum_b), .out_sat(out_sat_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [11:0] p);
        in_valid = 1'b1;
        p_in = p;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; clr = 1'b0; in_valid = 1'b0; p_in = '0; out_ready = 1'b0;
        tick();
        tick();
        check("rst_valid", out_valid_a, 0);
        check("rst_sum", out_sum_a, 0);
        check("rst_sat", out_sat_a, 0);
        check("rst_in_ready", in_ready_a, 0);
        rst_n = 1'b1;
        en = 1'b1;
        out_ready = 1'b1;
        feed(1); feed(4); feed(16);
        check("t2_no_early_valid", out_valid_a, 0);
        feed(1);
        check("t2_valid", out_valid_a, 1);
        check("t2_sum", out_sum_a, 22);
        check("t2_sat", out_sat_a, 0);
        tick();
        check("t2_popped", out_valid_a, 0);
        out_ready = 1'b0;
        feed(1); feed(4); feed(16); feed(1);
        check("t3_hold_valid", out_valid_a, 1);
        check("t3_hold_sum", out_sum_a, 22);
        feed(10); feed(10); feed(10);
        in_valid = 1'b1;
        p_in = 12'd10;
        #1;
        check("t3_stall_ready", in_ready_a, 0);
        tick();
        check("t3_stall_sum", out_sum_a, 22);
        check("t3_stall_valid", out_valid_a, 1);
        out_ready = 1'b1;
        #1;
        check("t3_unstall_ready", in_ready_a, 1);
        tick();
        in_valid = 1'b0;
        check("t3_nobubble_valid", out_valid_a, 1);
        check("t3_sum40", out_sum_a, 40);
        tick();
        check("t3_drained", out_valid_a, 0);
        feed(4095); feed(4095); feed(4095); feed(4095);
        check("t4_sat_sum", out_sum_b, 4095);
        check("t4_sat_flag", out_sat_b, 1);
        check("t4_wide_sum", out_sum_a, 16380);
        check("t4_wide_sat", out_sat_a, 0);
        feed(1); feed(1); feed(1); feed(1);
        check("t4_next_sum", out_sum_b, 4);
        check("t4_next_sat", out_sat_b, 0);
        feed(5); feed(5);
        clr = 1'b1;
        in_valid = 1'b1;
        p_in = 12'd5;
        tick();
        clr = 1'b0;
        in_valid = 1'b0;
        check("t5_clr_sum", out_sum_a, 0);
        check("t5_clr_valid", out_valid_a, 0);
        feed(2); feed(2); feed(2);
        check("t5_partial", out_valid_a, 0);
        feed(2);
        check("t5_sum8", out_sum_a, 8);
        out_ready = 1'b0;
        feed(1); feed(1); feed(1); feed(1);
        feed(7);
        check("t6_pending", out_valid_a, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_valid", out_valid_a, 0);
        check("t6_async_sum", out_sum_a, 0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        feed(3); feed(3); feed(3);
        check("t6_partial", out_valid_a, 0);
        feed(3);
        check("t6_sum12", out_sum_a, 12);
        check("t6_valid", out_valid_a, 1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
